// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin pick helper for the 4-way arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // First asserted request at or above ptr, wrapping 3->0; returns ptr when req is empty.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] pick;
    pick = ptr;
    // Walk from the farthest offset down so the nearest hit wins.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder2to4.sv
// Binary-to-one-hot decoder with an enable; all zeros when disabled.
module decoder2to4 (
  input  logic [1:0] in,
  input  logic       en,
  output logic [3:0] out
);

  // Shift a single one into position when enabled.
  always_comb begin
    out = 4'b0000;
    if (en) out = 4'b0001 << in;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a one-cycle bubble between grants.
// Optional hold limit: define ARB_TIMEOUT_EN to force a release after TIMEOUT
// grant cycles and pulse timeout_err; otherwise grants are held indefinitely.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout_err
);

  // A zero hold limit cannot be honoured.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("rr_arbiter4: TIMEOUT must be at least 1");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_last;

  // Counter reaches TIMEOUT-1 during the last permitted grant cycle.
  assign hold_last = (hold_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_err = 1'b0;
`endif

  // Next owner candidate when leaving IDLE.
  always_comb begin
    pick = rr_pick(req, ptr);
  end

  // Arbitration state machine with registered grant index and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
      hold_cnt    <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            gnt_idx   <= pick;
            gnt_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          if (!req[gnt_idx]) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + IDX_W'(1);
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_last) begin
            state       <= IDLE;
            gnt_valid   <= 1'b0;
            ptr         <= gnt_idx + IDX_W'(1);
            timeout_err <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-hot grant derived from the registered index, gated by valid.
  decoder2to4 u_dec (
    .in  (gnt_idx),
    .en  (gnt_valid),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: reference model feeds a scoreboard queue,
// a monitor pops it every cycle, and directed checks pin the key scenarios.
module tb_rr_arbiter4;

  localparam int unsigned TB_TIMEOUT = 4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       terr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  // Reference model state: cycles the current grant has been visible.
  logic       m_busy = 1'b0;
  logic [1:0] m_idx  = 2'd0;
  logic [1:0] m_ptr  = 2'd0;
  logic       m_terr = 1'b0;
  int         m_hold = 0;

  rr_arbiter4 #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic [3:0] r, input logic rs);
    int c;
    if (rs) begin
      m_busy = 1'b0;
      m_idx  = 2'd0;
      m_ptr  = 2'd0;
      m_terr = 1'b0;
      m_hold = 0;
    end else begin
      m_terr = 1'b0;
      if (!m_busy) begin
        if (r != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            c = (int'(m_ptr) + k) % 4;
            if (r[c]) begin
              m_idx = 2'(c);
              break;
            end
          end
          m_busy = 1'b1;
          m_hold = 1;
        end
      end else if (!r[m_idx]) begin
        m_busy = 1'b0;
        m_ptr  = 2'((int'(m_idx) + 1) % 4);
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_hold == int'(TB_TIMEOUT)) begin
        m_busy = 1'b0;
        m_ptr  = 2'((int'(m_idx) + 1) % 4);
        m_terr = 1'b1;
      end
`endif
      else begin
        m_hold++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.gnt  = m_busy ? (4'b0001 << m_idx) : 4'b0000;
    e.idx  = m_idx;
    e.vld  = m_busy;
    e.terr = m_terr;
    return e;
  endfunction

  // Drive one cycle of stimulus, push its expected result, return after the edge.
  task automatic step(input logic [3:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    model_edge(r, rs);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare scoreboard entry and grant invariants after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("sb_gnt",  8'(gnt),         8'(e.gnt));
      check("sb_idx",  8'(gnt_idx),     8'(e.idx));
      check("sb_vld",  8'(gnt_valid),   8'(e.vld));
      check("sb_terr", 8'(timeout_err), 8'(e.terr));
    end
    check("onehot",  8'($countones(gnt) <= 1), 8'd1);
    check("gnt_dec", 8'(gnt), gnt_valid ? 8'(4'b0001 << gnt_idx) : 8'd0);
  end

  initial begin
    int         order[5];
    logic [3:0] own_m;
    logic [3:0] r;
    logic       rs;

    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = 4'b0000;

    // Reset state
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("rst_gnt",  8'(gnt),         8'h00);
    check("rst_idx",  8'(gnt_idx),     8'h00);
    check("rst_vld",  8'(gnt_valid),   8'h00);
    check("rst_terr", 8'(timeout_err), 8'h00);

    // Single request to requester 2, then release moves ptr to 3
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    check("single_gnt", 8'(gnt),     8'h04);
    check("single_idx", 8'(gnt_idx), 8'h02);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    check("single_drop", 8'(gnt),     8'h00);
    check("single_ptr",  8'(dut.ptr), 8'h03);
    check("single_hold_idx", 8'(gnt_idx), 8'h02);

    // Wrap priority from ptr=3
    step(4'b1001, 1'b0);
    check("wrap_first", 8'(gnt), 8'h08);
    step(4'b0001, 1'b0);
    check("wrap_bubble", 8'(gnt), 8'h00);
    step(4'b0001, 1'b0);
    check("wrap_second", 8'(gnt), 8'h01);
    step(4'b0000, 1'b0);

    // Full contention from a fresh pointer: 0,1,2,3,0
    step(4'b0000, 1'b1);
    for (int j = 0; j < 5; j++) begin
      own_m = 4'b0001 << order[j];
      step(4'b1111, 1'b0);
      check("cont_gnt", 8'(gnt), 8'(own_m));
      step(4'b1111, 1'b0);
      check("cont_hold", 8'(gnt), 8'(own_m));
      step(~own_m, 1'b0);
      check("cont_bubble", 8'(gnt), 8'h00);
    end
    step(4'b0000, 1'b0);

    // Reset in the middle of a grant
    step(4'b0010, 1'b0);
    check("midrst_pre", 8'(gnt), 8'h02);
    step(4'b0010, 1'b1);
    check("midrst_gnt",  8'(gnt),         8'h00);
    check("midrst_idx",  8'(gnt_idx),     8'h00);
    check("midrst_terr", 8'(timeout_err), 8'h00);
    step(4'b0011, 1'b0);
    check("midrst_after", 8'(gnt), 8'h01);
    step(4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Held request is forced off after TB_TIMEOUT cycles, then re-granted
    step(4'b0000, 1'b1);
    for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
      step(4'b0001, 1'b0);
      check("to_hold", 8'(gnt), 8'h01);
      check("to_noerr", 8'(timeout_err), 8'h00);
    end
    step(4'b0001, 1'b0);
    check("to_release", 8'(gnt), 8'h00);
    check("to_err", 8'(timeout_err), 8'h01);
    step(4'b0001, 1'b0);
    check("to_regrant", 8'(gnt), 8'h01);
    check("to_err_clr", 8'(timeout_err), 8'h00);
    step(4'b0000, 1'b0);
`else
    // Grant hold is unbounded without the timeout feature
    step(4'b0100, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b0100, 1'b0);
    check("long_hold", 8'(gnt), 8'h04);
    check("long_noerr", 8'(timeout_err), 8'h00);
    step(4'b0000, 1'b0);
`endif

    // Random traffic with occasional resets; requesters hold briefly
    r = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 49) == 0);
      step(r, rs);
    end
    step(4'b0000, 1'b0);

    @(negedge clk);
    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=done");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of consecutive cycles one grant may be held (only used with ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: request from requester i on bit i.
REQ-005 The block SHALL have port gnt, output, 4 bits: one-hot grant, all zeros when no grant is held.
REQ-006 The block SHALL have port gnt_idx, output, 2 bits: binary index of the current or last granted requester.
REQ-007 The block SHALL have port gnt_valid, output, 1 bit: high while a grant is held.
REQ-008 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and BUSY (grant held).
REQ-010 In IDLE with req != 0, the block SHALL select the first asserted bit searching upward from ptr with wrap 3->0, and SHALL register gnt_idx, set gnt_valid and enter BUSY at the same edge; latency is request sampled in cycle N, grant visible in cycle N+1.
REQ-011 In IDLE with req == 0, the block SHALL remain in IDLE with gnt_valid=0 and gnt=0.
REQ-012 gnt SHALL equal the one-hot decode of gnt_idx when gnt_valid=1, and 4'b0000 otherwise; gnt SHALL never have more than one bit set.
REQ-013 In BUSY, the grant SHALL be held while req[gnt_idx]=1; requests from other requesters SHALL be ignored.
REQ-014 In BUSY, when req[gnt_idx]=0 is sampled, the block SHALL at that edge clear gnt_valid, set ptr=(gnt_idx+1) mod 4 and return to IDLE.
REQ-015 Exactly one bubble cycle (gnt=0) SHALL separate consecutive grants.
REQ-016 gnt_idx SHALL hold its last value in IDLE.
REQ-017 ptr SHALL be a 2-bit internal register; increment wraps 3->0 by natural 2-bit overflow.

Reset
REQ-018 On any clock edge with rst=1, the block SHALL go to IDLE with gnt=0, gnt_idx=0, gnt_valid=0, timeout_err=0, ptr=0 and the hold counter=0, regardless of the current state or req.
REQ-019 Reset asserted mid-grant SHALL drop gnt on the next edge, with no timeout_err pulse.
REQ-020 The first arbitration after reset SHALL have priority order 0,1,2,3.

Configuration
REQ-021 With macro ARB_TIMEOUT_EN defined, the block SHALL count the cycles gnt_valid=1; after TIMEOUT cycles of one grant, the block SHALL force the release as in REQ-014 and pulse timeout_err high for exactly that one cycle (the first IDLE cycle).
REQ-022 With ARB_TIMEOUT_EN defined, the hold counter SHALL be sized $clog2(TIMEOUT+1) bits and cleared at every new grant.
REQ-023 Without ARB_TIMEOUT_EN, the block SHALL have no counter, the grant hold SHALL be unbounded, and timeout_err SHALL be tied to 0; the port list SHALL be identical in both builds.

Structure
REQ-024 Package arb_pkg SHALL hold the state enum typedef (IDLE, BUSY), the constant NUM_REQ=4 and the constant IDX_W=2.
REQ-025 The one-hot gnt generation SHALL instantiate the existing 2-to-4 decoder sub-module decoder2to4 (in = gnt_idx, out gated by gnt_valid).

Verification
REQ-026 The bench SHALL cover single request: req=4'b0100 at cycle 2 -> gnt=4'b0100 and gnt_idx=2 at cycle 3; req dropped at cycle 6 -> gnt=0 at cycle 7 and ptr=3.
REQ-027 The bench SHALL cover full contention: req=4'b1111, each owner drops its request after 2 grant cycles -> grant order 0,1,2,3,0 with one zero cycle between grants.
REQ-028 The bench SHALL cover wrap priority: ptr=3 (after a grant to 2), then req=4'b1001 -> gnt=4'b1000, then gnt=4'b0001.
REQ-029 The bench SHALL cover reset mid-grant: gnt=4'b0010, then rst=1 for 1 cycle -> gnt=0, gnt_idx=0, timeout_err=0; req=4'b0011 afterwards -> gnt=4'b0001.
REQ-030 With ARB_TIMEOUT_EN and TIMEOUT=4, the bench SHALL hold req=4'b0001 -> gnt high for exactly 4 cycles, timeout_err=1 for one cycle, then gnt=4'b0001 re-granted after the bubble.
REQ-031 On every cycle the bench SHALL check that gnt is one-hot or zero and that gnt===(gnt_valid ? 1<<gnt_idx : 0).
